// File: rtl/mod_arbiter.sv
// Round-robin arbiter/sequencer that shares one iterative WIDTH-bit mod unit between two requesters.
// Optional watchdog on the BUSY wait is compiled in with `define MOD_ARB_TIMEOUT_EN.
module mod_arbiter #(
  parameter int WIDTH = 32
`ifdef MOD_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic             ack0_o,
  output logic             ack1_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o,
  output logic             mod_en_o,
  output logic [WIDTH-1:0] mod_a_o,
  output logic [WIDTH-1:0] mod_b_o,
  input  logic [WIDTH-1:0] mod_result_i,
  input  logic             mod_we_i,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic             zb_q, zb_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             err_q, err_d;
  logic             mod_en_q, mod_en_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mod_a_q, mod_a_d, mod_b_q, mod_b_d;
  logic             grant;
  logic [WIDTH-1:0] sel_a, sel_b;
`ifdef MOD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  // Requesters only handshake via Ack/Done: Req is held until Ack, Done marks Result/Err valid.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    zb_d     = zb_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = 1'b0;
    mod_en_d = mod_en_q;
    result_d = result_q;
    mod_a_d  = mod_a_q;
    mod_b_d  = mod_b_q;
    grant    = (req0_i && req1_i) ? ptr_q : req1_i;
    sel_a    = grant ? a1_i : a0_i;
    sel_b    = grant ? b1_i : b0_i;
`ifdef MOD_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        mod_en_d = 1'b0;
        if (req0_i || req1_i) begin
          owner_d = grant;
          mod_a_d = sel_a;
          mod_b_d = sel_b;
          ack0_d  = ~grant;
          ack1_d  = grant;
          if (sel_b != '0) begin
            state_d  = BUSY;
            mod_en_d = 1'b1;
`ifdef MOD_ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            state_d = RESP;
            zb_d    = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mod_we_i) begin
          state_d  = RESP;
          mod_en_d = 1'b0;
          result_d = mod_result_i;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
`ifdef MOD_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = RESP;
          mod_en_d = 1'b0;
          result_d = '0;
          err_d    = 1'b1;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        mod_en_d = 1'b0;
        // Zero-divisor runs spend an extra RESP cycle so Done lands one cycle after Ack.
        if (zb_q) begin
          zb_d     = 1'b0;
          result_d = '0;
          err_d    = 1'b1;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
        end else begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      zb_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
      mod_en_q <= 1'b0;
      result_q <= '0;
      mod_a_q  <= '0;
      mod_b_q  <= '0;
`ifdef MOD_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      zb_q     <= zb_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err_q    <= err_d;
      mod_en_q <= mod_en_d;
      result_q <= result_d;
      mod_a_q  <= mod_a_d;
      mod_b_q  <= mod_b_d;
`ifdef MOD_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign done0_o  = done0_q;
  assign done1_o  = done1_q;
  assign err_o    = err_q;
  assign mod_en_o = mod_en_q;
  assign result_o = result_q;
  assign mod_a_o  = mod_a_q;
  assign mod_b_o  = mod_b_q;
  assign state_o  = state_q;

endmodule
